cpc_fifo_ctrl: RTL and testbench

Host-side Z80 I/O controller for the CPC↔Pi FIFO link, implemented in the XC9572XL CPLD.
- Decodes CPC I/O cycles on the data and status ports and drives the 74HCT40105 host-side controls (`host_fifo_si`, `host_fifo_sob`, `host_fifo_oeb`, `host_fifo_reset`).
- Returns a status byte built from the FIFO ready flags and sticky error flags.
- Sits between the CPC edge connector and the four FIFO devices.

---
 rtl/cpc_fifo_ctrl_pkg.sv | 26 ++
 rtl/cpc_fifo_ctrl_if.sv | 13 +
 rtl/cpc_fifo_ctrl_sync2.sv | 27 ++
 rtl/cpc_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpc_fifo_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpc_fifo_ctrl_pkg.sv
// Shared constants for the CPC host-side FIFO controller: FSM encodings,
// status bit positions and I/O port offsets.
package cpc_fifo_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_SI   = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_RD_SO   = 3'd4;
  localparam logic [2:0] ST_RST     = 3'd5;

  localparam int STA_DOR = 0;
  localparam int STA_DIR = 1;
  localparam int STA_OVF = 2;
  localparam int STA_UNF = 3;

  localparam logic [15:0] PORT_DATA = 16'd0;
  localparam logic [15:0] PORT_STA  = 16'd1;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cpc_fifo_ctrl_if.sv
// Z80 I/O bus as seen by the controller: address, strobes and the data bus halves.
interface cpc_fifo_ctrl_if;
  logic [15:0] A;
  logic        IOREQ_B;
  logic        RD_B;
  logic        WR_B;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;

  modport master (output A, IOREQ_B, RD_B, WR_B, d_in, input d_out, d_oe);
  modport slave  (input A, IOREQ_B, RD_B, WR_B, d_in, output d_out, d_oe);
endinterface

// File: rtl/cpc_fifo_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous FIFO ready flags.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  logic meta_d, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/cpc_fifo_ctrl.sv
// Host-side Z80 I/O controller for the CPC<->Pi FIFO link: decodes the data and
// status ports and sequences the 74HCT40105 shift/reset controls.
//
// state   | meaning
// IDLE    | waiting for a decoded access
// WR_SI   | shift-in pulse to FIFO0 in progress
// WR_WAIT | write handled, waiting for the I/O cycle to end
// RD_WAIT | FIFO1 output on the bus, waiting for the I/O cycle to end
// RD_SO   | one-cycle shift-out to FIFO1 after the read
// RST     | master reset pulse to all FIFOs, clears sticky flags
module cpc_fifo_ctrl
  import cpc_fifo_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE  = 16'hFD80,
  parameter int          SI_CYCLES  = 1,
  parameter int          RST_CYCLES = 4,
  parameter logic [3:0]  VERSION    = 4'h1
) (
  input  logic                  CLK,
  input  logic                  RESET_B,
  cpc_fifo_ctrl_if.slave        bus,
  input  logic                  fifo_host_dir,
  input  logic                  fifo_host_dor,
  output logic                  host_fifo_si,
  output logic                  host_fifo_sob,
  output logic                  host_fifo_oeb,
  output logic                  host_fifo_reset,
  output logic                  WAIT_B
);
  localparam int CNT_W = cnt_width(SI_CYCLES, RST_CYCLES);
  localparam logic [CNT_W-1:0] SI_LAST  = CNT_W'(SI_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  logic dir_s, dor_s;
  logic io_rd, io_wr, at_data, at_sta;
  logic wr_dat, rd_dat, wr_sta, rd_sta;
  logic unused_d_in;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             had_dor_q, had_dor_d;

  sync2 u_sync_dir (.clk(CLK), .rst_n(RESET_B), .d(fifo_host_dir), .q(dir_s));
  sync2 u_sync_dor (.clk(CLK), .rst_n(RESET_B), .d(fifo_host_dor), .q(dor_s));

  assign io_rd   = !bus.IOREQ_B && !bus.RD_B;
  assign io_wr   = !bus.IOREQ_B && !bus.WR_B;
  assign at_data = (bus.A == ADDR_BASE + PORT_DATA);
  assign at_sta  = (bus.A == ADDR_BASE + PORT_STA);
  assign wr_dat  = io_wr && at_data;
  assign rd_dat  = io_rd && at_data;
  assign wr_sta  = io_wr && at_sta;
  assign rd_sta  = io_rd && at_sta;

  // Only bit 7 of a status write means anything (FIFO reset request).
  assign unused_d_in = ^bus.d_in[6:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    had_dor_d = had_dor_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_dat) begin
          cnt_d = '0;
          if (dir_s) begin
            state_d = ST_WR_SI;
          end else begin
            ovf_d   = 1'b1;
            state_d = ST_WR_WAIT;
          end
        end else if (rd_dat) begin
          state_d   = ST_RD_WAIT;
          had_dor_d = dor_s;
          if (!dor_s) unf_d = 1'b1;
        end else if (wr_sta && bus.d_in[7]) begin
          state_d = ST_RST;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      ST_WR_SI: begin
        if (cnt_q == SI_LAST) begin
          state_d = ST_WR_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_WAIT: if (!wr_dat) state_d = ST_IDLE;
      ST_RD_WAIT: if (!rd_dat) state_d = had_dor_q ? ST_RD_SO : ST_IDLE;
      ST_RD_SO:   state_d = ST_IDLE;
      ST_RST: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (cnt_q == RST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      had_dor_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      had_dor_q <= had_dor_d;
    end
  end

  // Pulses decode straight from the state register, so async reset kills them at once.
  assign host_fifo_si    = (state_q == ST_WR_SI);
  assign host_fifo_sob   = (state_q != ST_RD_SO);
  assign host_fifo_reset = (state_q == ST_RST);
  assign host_fifo_oeb   = !(rd_dat && RESET_B);
  assign WAIT_B          = 1'b1;

  assign bus.d_oe  = rd_sta;
  assign bus.d_out = {VERSION, unf_q, ovf_q, dir_s, dor_s};
endmodule

// File: tb/tb_cpc_fifo_ctrl.sv
// Directed bench for cpc_fifo_ctrl: a table of Z80 I/O cycles with hand-computed
// pulse counts and status bytes, plus power-up and mid-pulse reset sequences.
module tb_cpc_fifo_ctrl;
  logic CLK = 1'b0;
  logic RESET_B = 1'b0;
  logic dir = 1'b1;
  logic dor = 1'b0;
  logic si, sob, oeb, frst, wait_b;

  cpc_fifo_ctrl_if bus ();

  cpc_fifo_ctrl dut (
    .CLK            (CLK),
    .RESET_B        (RESET_B),
    .bus            (bus.slave),
    .fifo_host_dir  (dir),
    .fifo_host_dor  (dor),
    .host_fifo_si   (si),
    .host_fifo_sob  (sob),
    .host_fifo_oeb  (oeb),
    .host_fifo_reset(frst),
    .WAIT_B         (wait_b)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  bit mon_en = 0;
  int n_si, n_si_out, n_sob, n_sob_early, n_rst, n_oeb, n_oeb_out;

  task automatic clear_mon();
    n_si = 0; n_si_out = 0; n_sob = 0; n_sob_early = 0;
    n_rst = 0; n_oeb = 0; n_oeb_out = 0;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (si) begin
        n_si++;
        if (bus.WR_B) n_si_out++;
      end
      if (!sob) begin
        n_sob++;
        if (!bus.RD_B) n_sob_early++;
      end
      if (frst) n_rst++;
      if (!oeb) begin
        n_oeb++;
        if (bus.IOREQ_B || bus.RD_B) n_oeb_out++;
      end
    end
  end

  task automatic bus_idle();
    bus.IOREQ_B = 1'b1;
    bus.RD_B    = 1'b1;
    bus.WR_B    = 1'b1;
  endtask

  task automatic bus_cycle(input bit wr, input logic [15:0] addr, input logic [7:0] data);
    @(posedge CLK); #2;
    bus.A = addr;
    bus.d_in = data;
    @(posedge CLK); #2;
    bus.IOREQ_B = 1'b0;
    if (wr) bus.WR_B = 1'b0; else bus.RD_B = 1'b0;
    repeat (3) @(posedge CLK);
    #2 bus_idle();
  endtask

  task automatic read_status(output logic [7:0] val, output logic oe);
    @(posedge CLK); #2;
    bus.A = 16'hFD81;
    @(posedge CLK); #2;
    bus.IOREQ_B = 1'b0;
    bus.RD_B = 1'b0;
    @(negedge CLK);
    val = bus.d_out;
    oe  = bus.d_oe;
    @(posedge CLK); #2 bus_idle();
    repeat (2) @(posedge CLK);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          dir;
    bit          dor;
    int          e_si;
    int          e_sob;
    int          e_rst;
    int          e_oeb;
    logic [7:0]  e_sta;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  logic [7:0] sta;
  logic       sta_oe;

  initial begin
    //             wr    addr      data   dir dor si sob rst oeb status
    vecs[0]  = '{1'b1, 16'hFD80, 8'h5A, 1, 0, 1, 0, 0, 0, 8'h12};
    vecs[1]  = '{1'b0, 16'hFD80, 8'h00, 1, 1, 0, 1, 0, 3, 8'h13};
    vecs[2]  = '{1'b1, 16'hFD80, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h14};
    vecs[3]  = '{1'b1, 16'hFD81, 8'h00, 0, 0, 0, 0, 0, 0, 8'h14};
    vecs[4]  = '{1'b1, 16'hFD81, 8'h80, 1, 0, 0, 0, 4, 0, 8'h12};
    vecs[5]  = '{1'b0, 16'hFD80, 8'h00, 1, 0, 0, 0, 0, 3, 8'h1A};
    vecs[6]  = '{1'b1, 16'hFD80, 8'h33, 0, 0, 0, 0, 0, 0, 8'h1C};
    vecs[7]  = '{1'b1, 16'hFC80, 8'h44, 1, 1, 0, 0, 0, 0, 8'h1F};
    vecs[8]  = '{1'b0, 16'hFD82, 8'h00, 1, 1, 0, 0, 0, 0, 8'h1F};
    vecs[9]  = '{1'b0, 16'hFC80, 8'h00, 1, 1, 0, 0, 0, 0, 8'h1F};
    vecs[10] = '{1'b1, 16'hFD81, 8'h80, 1, 1, 0, 0, 4, 0, 8'h13};
    vecs[11] = '{1'b0, 16'hFD81, 8'h00, 1, 1, 0, 0, 0, 0, 8'h13};

    // Power-up: outputs held safe even with a data read decoded during reset.
    bus.A = 16'hFD80;
    bus.d_in = 8'h00;
    bus.IOREQ_B = 1'b0;
    bus.RD_B = 1'b0;
    bus.WR_B = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_si", si, 0);
    check("rst_sob", sob, 1);
    check("rst_oeb", oeb, 1);
    check("rst_pulse", frst, 1);
    check("wait_b", wait_b, 1);
    check("rst_status_flags", bus.d_out[3:2], 0);
    bus_idle();
    @(posedge CLK); #2;
    clear_mon();
    mon_en = 1;
    RESET_B = 1'b1;
    repeat (10) @(posedge CLK);
    #2 mon_en = 0;
    check("powerup_rst_cycles", n_rst, 4);
    check("powerup_rst_low", frst, 0);
    read_status(sta, sta_oe);
    check("powerup_status", sta, 8'h12);
    check("powerup_status_oe", sta_oe, 1);
    check("idle_d_oe", bus.d_oe, 0);

    for (int i = 0; i < NV; i++) begin
      dir = vecs[i].dir;
      dor = vecs[i].dor;
      repeat (4) @(posedge CLK);
      #2;
      clear_mon();
      mon_en = 1;
      bus_cycle(vecs[i].wr, vecs[i].addr, vecs[i].data);
      repeat (8) @(posedge CLK);
      #2 mon_en = 0;
      check($sformatf("v%0d_si", i), n_si, vecs[i].e_si);
      check($sformatf("v%0d_sob", i), n_sob, vecs[i].e_sob);
      check($sformatf("v%0d_rst", i), n_rst, vecs[i].e_rst);
      check($sformatf("v%0d_oeb", i), n_oeb, vecs[i].e_oeb);
      check($sformatf("v%0d_window", i), n_si_out + n_sob_early + n_oeb_out, 0);
      read_status(sta, sta_oe);
      check($sformatf("v%0d_status", i), sta, vecs[i].e_sta);
      check($sformatf("v%0d_status_oe", i), sta_oe, 1);
    end

    // Reset asserted in the middle of a shift-in pulse.
    begin
      bit seen;
      seen = 0;
      dir = 1'b1;
      repeat (4) @(posedge CLK);
      #2 bus.A = 16'hFD80;
      bus.d_in = 8'hC3;
      @(posedge CLK); #2;
      bus.IOREQ_B = 1'b0;
      bus.WR_B = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
        @(negedge CLK);
        if (si) seen = 1;
      end
      check("midsi_si_seen", seen, 1);
      #1 RESET_B = 1'b0;
      #1;
      check("midsi_si_async_low", si, 0);
      check("midsi_rst_high", frst, 1);
      @(posedge CLK); #2 bus_idle();
      repeat (2) @(posedge CLK);
      #2;
      clear_mon();
      mon_en = 1;
      RESET_B = 1'b1;
      repeat (10) @(posedge CLK);
      #2 mon_en = 0;
      check("midsi_rst_cycles", n_rst, 4);
      check("midsi_si_after", n_si, 0);
      check("midsi_rst_low", frst, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
